// File: rtl/perf_pkg.sv
// Shared constants and sum helpers for perf_counter_bank and its counter cells.
// The PERF_CNT_THRESH_EN macro is consumed by the cell and the top, not here.
package perf_pkg;

    localparam int PERF_NUM_CH = 8;
    localparam int PERF_CNT_W  = 32;
    localparam int PERF_INC_W  = 3;

    localparam int CH_HIT         = 0;
    localparam int CH_MISS        = 1;
    localparam int CH_EVICT       = 2;
    localparam int CH_DIRTY_EVICT = 3;
    localparam int CH_PRED_HIT    = 4;
    localparam int CH_PRED_MISS   = 5;
    localparam int CH_STALE       = 6;

    // Carry out of a w-bit add; operands are zero-extended to 64 bits by the caller.
    function automatic logic perf_carry(input logic [63:0] cnt, input logic [63:0] inc,
                                        input logic [6:0] w);
        logic [64:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[w];
    endfunction

    function automatic logic [63:0] perf_sum(input logic [63:0] cnt, input logic [63:0] inc,
                                             input logic [6:0] w, input logic sat);
        logic [64:0] sum;
        logic [63:0] lim;
        sum = {1'b0, cnt} + {1'b0, inc};
        lim = (64'd1 << w) - 64'd1;
        if (sum[w]) begin
            return sat ? lim : (sum[63:0] & lim);
        end
        return sum[63:0] & lim;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: live accumulator, shadow copy and sticky overflow.
// Define PERF_CNT_THRESH_EN to add a per-channel threshold with a sticky hit flag.
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_W = PERF_CNT_W,
    parameter int INC_W = PERF_INC_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [INC_W-1:0] inc_i,
    input  logic             sat_i,
    input  logic             clr_i,
    input  logic             snap_i,
`ifdef PERF_CNT_THRESH_EN
    input  logic             thr_wr_i,
    input  logic [CNT_W-1:0] thr_val_i,
    output logic             thr_hit_o,
`endif
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] shadow_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             ovf_q, ovf_d;

    // Shadow captures the pre-update value, so snap with clr reads out before clearing.
    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        shadow_d = snap_i ? cnt_q : shadow_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en_i && (inc_i != '0)) begin
            cnt_d = CNT_W'(perf_sum(64'(cnt_q), 64'(inc_i), 7'(CNT_W), sat_i));
            if (perf_carry(64'(cnt_q), 64'(inc_i), 7'(CNT_W))) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign shadow_o = shadow_q;
    assign ovf_o    = ovf_q;

`ifdef PERF_CNT_THRESH_EN
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             hit_q, hit_d;

    // Compare uses the registered threshold, so a same-cycle write sees the old value.
    always_comb begin
        thr_d = thr_wr_i ? thr_val_i : thr_q;
        hit_d = clr_i ? 1'b0 : (hit_q | (cnt_q >= thr_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            thr_q <= '1;
            hit_q <= 1'b0;
        end else begin
            thr_q <= thr_d;
            hit_q <= hit_d;
        end
    end

    assign thr_hit_o = hit_q;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Parametrised bank of event counters with snapshot, indexed readout and sticky overflow.
// Define PERF_CNT_THRESH_EN to add per-channel threshold registers and thr_hit_o.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH = PERF_NUM_CH,
    parameter int CNT_W  = PERF_CNT_W,
    parameter int INC_W  = PERF_INC_W,
    parameter int SEL_W  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH*INC_W-1:0] ev_inc_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic                    cfg_sat_i,
    input  logic                    clr_i,
    input  logic                    snap_i,
    output logic                    snap_done_o,
    input  logic                    rd_req_i,
    input  logic [SEL_W-1:0]        rd_sel_i,
    input  logic                    rd_shadow_i,
    output logic                    rd_valid_o,
    output logic [CNT_W-1:0]        rd_data_o,
`ifdef PERF_CNT_THRESH_EN
    input  logic                    thr_wr_i,
    input  logic [SEL_W-1:0]        thr_sel_i,
    input  logic [CNT_W-1:0]        thr_val_i,
    output logic [NUM_CH-1:0]       thr_hit_o,
`endif
    output logic [NUM_CH-1:0]       ovf_o,
    output logic                    ovf_any_o
);

    localparam int NUM_SLOT = 1 << SEL_W;

    // Slots past NUM_CH read as zero, which covers out-of-range selects.
    logic [CNT_W-1:0]  live   [NUM_SLOT];
    logic [CNT_W-1:0]  shadow [NUM_SLOT];
    logic [NUM_CH-1:0] ovf;

    for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
        if (i < NUM_CH) begin : g_cell
            perf_counter_cell #(
                .CNT_W(CNT_W),
                .INC_W(INC_W)
            ) u_cell (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .en_i     (ch_en_i[i]),
                .inc_i    (ev_inc_i[i*INC_W +: INC_W]),
                .sat_i    (cfg_sat_i),
                .clr_i    (clr_i),
                .snap_i   (snap_i),
`ifdef PERF_CNT_THRESH_EN
                .thr_wr_i (thr_wr_i && (thr_sel_i == SEL_W'(i))),
                .thr_val_i(thr_val_i),
                .thr_hit_o(thr_hit_o[i]),
`endif
                .cnt_o    (live[i]),
                .shadow_o (shadow[i]),
                .ovf_o    (ovf[i])
            );
        end else begin : g_pad
            assign live[i]   = '0;
            assign shadow[i] = '0;
        end
    end

    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             snap_done_q, snap_done_d;
    logic             ovf_any_q, ovf_any_d;

    always_comb begin
        rd_valid_d  = rd_req_i;
        rd_data_d   = rd_data_q;
        snap_done_d = snap_i;
        ovf_any_d   = |ovf;
        if (rd_req_i) begin
            rd_data_d = rd_shadow_i ? shadow[rd_sel_i] : live[rd_sel_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            snap_done_q <= 1'b0;
            ovf_any_q   <= 1'b0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            snap_done_q <= snap_done_d;
            ovf_any_q   <= ovf_any_d;
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign snap_done_o = snap_done_q;
    assign ovf_any_o   = ovf_any_q;
    assign ovf_o       = ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed corner sequences, a read-vector
// table, and a randomized phase checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_perf_counter_bank;

    localparam int NCH  = 6;
    localparam int CW   = 8;
    localparam int IW   = 3;
    localparam int SW   = 3;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, cfgSat, clr, snap, rdReq, rdShadow;
    logic [NCH*IW-1:0] evInc;
    logic [NCH-1:0]    chEn;
    logic [SW-1:0]     rdSel;
    logic              snapDone, rdValid, ovfAny;
    logic [CW-1:0]     rdData;
    logic [NCH-1:0]    ovf;

    int checks   = 0;
    int failures = 0;

    // Reference model state, expressed as plain integers.
    int mLive[NCH];
    int mShadow[NCH];
    bit mOvf[NCH];
    bit mSnapDone, mRdValid, mOvfAny;
    int mRdData;

    perf_counter_bank #(
        .NUM_CH(NCH),
        .CNT_W (CW),
        .INC_W (IW),
        .SEL_W (SW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ev_inc_i   (evInc),
        .ch_en_i    (chEn),
        .cfg_sat_i  (cfgSat),
        .clr_i      (clr),
        .snap_i     (snap),
        .snap_done_o(snapDone),
        .rd_req_i   (rdReq),
        .rd_sel_i   (rdSel),
        .rd_shadow_i(rdShadow),
        .rd_valid_o (rdValid),
        .rd_data_o  (rdData),
        .ovf_o      (ovf),
        .ovf_any_o  (ovfAny)
    );

    typedef struct {
        logic [SW-1:0] sel;
        logic          shadow;
        int            expData;
    } rdVec_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance one clock edge with the currently driven inputs and step the model.
    task automatic applyStimulus();
        int nLive[NCH];
        int nShadow[NCH];
        bit nOvf[NCH];
        bit nOvfAny;
        int nRdData, inc, s, sel;
        nOvfAny = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            nOvfAny    = nOvfAny | mOvf[i];
            nShadow[i] = snap ? mLive[i] : mShadow[i];
            nLive[i]   = mLive[i];
            nOvf[i]    = mOvf[i];
            inc        = int'(evInc[i*IW +: IW]);
            if (clr) begin
                nLive[i] = 0;
                nOvf[i]  = 1'b0;
            end else if (chEn[i] && inc != 0) begin
                s = mLive[i] + inc;
                if (s > MAXV) begin
                    nOvf[i]  = 1'b1;
                    nLive[i] = cfgSat ? MAXV : s - (MAXV + 1);
                end else begin
                    nLive[i] = s;
                end
            end
        end
        sel     = int'(rdSel);
        nRdData = mRdData;
        if (rdReq) begin
            if (sel < NCH) nRdData = rdShadow ? mShadow[sel] : mLive[sel];
            else           nRdData = 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            mLive[i]   = rst ? 0 : nLive[i];
            mShadow[i] = rst ? 0 : nShadow[i];
            mOvf[i]    = rst ? 1'b0 : nOvf[i];
        end
        mSnapDone = rst ? 1'b0 : snap;
        mRdValid  = rst ? 1'b0 : rdReq;
        mRdData   = rst ? 0 : nRdData;
        mOvfAny   = rst ? 1'b0 : nOvfAny;
    endtask

    task automatic setInc(input int ch, input int v);
        evInc[ch*IW +: IW] = IW'(v);
    endtask

    task automatic doClear();
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0;
    endtask

    task automatic countTo(input int ch, input int target);
        int d;
        evInc = '0;
        chEn  = '1;
        while (mLive[ch] < target) begin
            d = target - mLive[ch];
            if (d > 7) d = 7;
            setInc(ch, d);
            applyStimulus();
        end
        evInc = '0;
    endtask

    task automatic expectRead(input string name, input int sel, input logic sh, input int exp);
        rdReq    = 1'b1;
        rdSel    = SW'(sel);
        rdShadow = sh;
        applyStimulus();
        rdReq = 1'b0;
        checkOutput({name, "_valid"}, 64'(rdValid), 64'd1);
        checkOutput({name, "_data"}, 64'(rdData), 64'(exp));
    endtask

    task automatic checkAll();
        logic [NCH-1:0] mv;
        for (int i = 0; i < NCH; i++) mv[i] = mOvf[i];
        checkOutput("rnd_rd_valid", 64'(rdValid), 64'(mRdValid));
        checkOutput("rnd_rd_data", 64'(rdData), 64'(mRdData));
        checkOutput("rnd_snap_done", 64'(snapDone), 64'(mSnapDone));
        checkOutput("rnd_ovf", 64'(ovf), 64'(mv));
        checkOutput("rnd_ovf_any", 64'(ovfAny), 64'(mOvfAny));
    endtask

    initial begin
        rdVec_t rdTable[6];
        rdTable[0] = '{sel: 3'd3, shadow: 1'b1, expData: 0};
        rdTable[1] = '{sel: 3'd0, shadow: 1'b0, expData: 10};
        rdTable[2] = '{sel: 3'd3, shadow: 1'b0, expData: 20};
        rdTable[3] = '{sel: 3'd7, shadow: 1'b0, expData: 0};
        rdTable[4] = '{sel: 3'd1, shadow: 1'b0, expData: 0};
        rdTable[5] = '{sel: 3'd3, shadow: 1'b0, expData: 20};

        rst = 1'b1; cfgSat = 1'b0; clr = 1'b0; snap = 1'b0;
        rdReq = 1'b0; rdShadow = 1'b0; rdSel = '0; evInc = '0; chEn = '1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset_rd_valid", 64'(rdValid), 64'd0);
        checkOutput("reset_rd_data", 64'(rdData), 64'd0);
        checkOutput("reset_snap_done", 64'(snapDone), 64'd0);
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
        checkOutput("reset_ovf_any", 64'(ovfAny), 64'd0);

        // Basic counting and streamed table reads.
        setInc(0, 1);
        setInc(3, 5);
        repeat (4) applyStimulus();
        setInc(3, 0);
        repeat (6) applyStimulus();
        evInc = '0;
        checkOutput("t1_valid_before_read", 64'(rdValid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            expectRead($sformatf("t1_read%0d", i), int'(rdTable[i].sel), rdTable[i].shadow,
                       rdTable[i].expData);
        end
        applyStimulus();
        checkOutput("t1_idle_valid", 64'(rdValid), 64'd0);
        checkOutput("t1_idle_data_hold", 64'(rdData), 64'd20);

        // Wrap then saturate on channel 1.
        doClear();
        cfgSat = 1'b0;
        countTo(1, 254);
        setInc(1, 3);
        applyStimulus();
        evInc = '0;
        checkOutput("t2_wrap_ovf", 64'(ovf), 64'b000010);
        checkOutput("t2_ovf_any_lag", 64'(ovfAny), 64'd0);
        expectRead("t2_wrap_val", 1, 1'b0, 1);
        checkOutput("t2_ovf_any_set", 64'(ovfAny), 64'd1);
        doClear();
        cfgSat = 1'b1;
        countTo(1, 254);
        setInc(1, 3);
        applyStimulus();
        evInc = '0;
        checkOutput("t2_sat_ovf", 64'(ovf), 64'b000010);
        expectRead("t2_sat_val", 1, 1'b0, 255);
        setInc(1, 1);
        applyStimulus();
        evInc = '0;
        expectRead("t2_sat_hold", 1, 1'b0, 255);
        cfgSat = 1'b0;

        // Enable mask on channel 2.
        doClear();
        chEn[2] = 1'b0;
        setInc(2, 7);
        repeat (5) applyStimulus();
        evInc = '0;
        expectRead("t3_masked", 2, 1'b0, 0);
        chEn[2] = 1'b1;
        setInc(2, 7);
        applyStimulus();
        evInc = '0;
        expectRead("t3_enabled", 2, 1'b0, 7);

        // Snapshot with clear, then back-to-back snaps.
        doClear();
        countTo(0, 42);
        snap = 1'b1; clr = 1'b1;
        setInc(0, 1);
        applyStimulus();
        snap = 1'b0; clr = 1'b0;
        evInc = '0;
        checkOutput("t4_snap_done_pulse", 64'(snapDone), 64'd1);
        applyStimulus();
        checkOutput("t4_snap_done_single", 64'(snapDone), 64'd0);
        expectRead("t4_shadow", 0, 1'b1, 42);
        expectRead("t4_live", 0, 1'b0, 0);
        snap = 1'b1;
        applyStimulus();
        checkOutput("t4_b2b_first", 64'(snapDone), 64'd1);
        applyStimulus();
        checkOutput("t4_b2b_second", 64'(snapDone), 64'd1);
        snap = 1'b0;
        applyStimulus();
        checkOutput("t4_b2b_end", 64'(snapDone), 64'd0);

        // Read on the same edge as an update; out-of-range selects.
        doClear();
        countTo(4, 9);
        setInc(4, 2);
        rdReq = 1'b1; rdSel = 3'd4; rdShadow = 1'b0;
        applyStimulus();
        rdReq = 1'b0;
        evInc = '0;
        checkOutput("t5_same_edge_valid", 64'(rdValid), 64'd1);
        checkOutput("t5_same_edge_data", 64'(rdData), 64'd9);
        expectRead("t5_after_update", 4, 1'b0, 11);
        expectRead("t5_sel7", 7, 1'b0, 0);
        expectRead("t5_sel6", 6, 1'b1, 0);

        // Reset in the middle of streamed reads with a snapshot pending.
        doClear();
        countTo(5, 255);
        setInc(5, 1);
        applyStimulus();
        setInc(5, 0);
        setInc(0, 3);
        applyStimulus();
        evInc = '0;
        snap = 1'b1;
        applyStimulus();
        snap = 1'b0;
        checkOutput("t6_ovf_before_rst", 64'(ovf), 64'b100000);
        rdReq = 1'b1; rdSel = 3'd0; rdShadow = 1'b0;
        applyStimulus();
        checkOutput("t6_read_before_rst", 64'(rdData), 64'd3);
        snap = 1'b1; rst = 1'b1;
        applyStimulus();
        snap = 1'b0; rst = 1'b0; rdReq = 1'b0;
        checkOutput("t6_rd_valid", 64'(rdValid), 64'd0);
        checkOutput("t6_rd_data", 64'(rdData), 64'd0);
        checkOutput("t6_snap_done", 64'(snapDone), 64'd0);
        checkOutput("t6_ovf", 64'(ovf), 64'd0);
        checkOutput("t6_ovf_any", 64'(ovfAny), 64'd0);
        expectRead("t6_live0", 0, 1'b0, 0);
        expectRead("t6_shadow0", 0, 1'b1, 0);
        expectRead("t6_live5", 5, 1'b0, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 79) == 0);
            clr      = ($urandom_range(0, 39) == 0);
            snap     = ($urandom_range(0, 7) == 0);
            cfgSat   = 1'($urandom_range(0, 1));
            chEn     = NCH'($urandom);
            evInc    = (NCH*IW)'($urandom);
            rdReq    = 1'($urandom_range(0, 1));
            rdSel    = SW'($urandom);
            rdShadow = 1'($urandom_range(0, 1));
            applyStimulus();
            checkAll();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised successor to the fixed seven-counter perf block behind the L1 cache top. Provides NUM_CH event counters with these capabilities:
- multi-event increments per cycle
- runtime wrap or saturate mode
- per-channel enable
- atomic snapshot into shadow registers
- registered indexed readout
- sticky overflow flags
The cache core, and any later core, drives the event lanes; the testbench and debug logic read through the readout port.

Parameters:
NUM_CH, 8, number of counter channels (1..32)
CNT_W, 32, counter width in bits (8..64)
INC_W, 3, width of the per-channel increment value per cycle
SEL_W, 3, readout select width; must satisfy 2**SEL_W >= NUM_CH

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
ev_inc  in  NUM_CH*INC_W  per-channel increment; channel i occupies bits [i*INC_W +: INC_W]
ch_en  in  NUM_CH  per-channel count enable
cfg_sat  in  1  1 = saturate at all-ones; 0 = wrap modulo 2**CNT_W
clr  in  1  synchronous clear of all live counters and overflow flags
snap  in  1  capture all live counters into shadow registers
snap_done  out  1  one-cycle pulse, the cycle after a snapshot is captured
rd_req  in  1  read request
rd_sel  in  SEL_W  channel index to read
rd_shadow  in  1  1 = read shadow register; 0 = read live counter
rd_valid  out  1  read data valid
rd_data  out  CNT_W  read data
ovf  out  NUM_CH  sticky per-channel overflow flags
ovf_any  out  1  OR of all ovf bits, registered

Behaviour:
- Reset (rst=1 at an edge):
  - all live counters, shadows and ovf bits = 0
  - snap_done=0, rd_valid=0, rd_data=0, ovf_any=0
  - reset overrides every other input, including mid-read or mid-snapshot.
- Count update, per channel i, each cycle with clr=0 and ch_en[i]=1:
  - sum = cnt + ev_inc_i, computed at CNT_W+1 bits.
  - If sum[CNT_W]=1: ovf[i] is set (sticky). cnt becomes all-ones when cfg_sat=1, or sum[CNT_W-1:0] when cfg_sat=0.
  - ch_en[i]=0 holds the counter; ev_inc_i=0 holds it and does not touch ovf.
  - A counter already at all-ones with cfg_sat=1 and a nonzero increment re-asserts ovf[i] (no change if already set).
- clr=1: all live counters and ovf bits are 0 at the next edge. That cycle's increments are dropped. Shadows are untouched.
- snap=1: every shadow[i] takes the live value as it stood before this cycle's update or clear.
  - snap_done pulses on the next cycle.
  - snap and clr together = read-and-clear: shadows hold the pre-clear values, live counters go to 0.
  - Back-to-back snaps are legal; each one produces its own snap_done pulse.
- Readout:
  - rd_req sampled at edge N; rd_valid=1 and rd_data valid during cycle N+1 (latency 1).
  - rd_data reflects the selected register's value before edge N's update.
  - One read per cycle, no backpressure; back-to-back reads stream at full rate.
  - rd_sel >= NUM_CH returns rd_data=0 with rd_valid=1.
  - When rd_req=0, rd_valid=0 and rd_data holds its last value.
- ovf_any is registered one cycle after the ovf bits, i.e. it lags them by one cycle.
- No internal state machine beyond the per-channel accumulators. Snapshot and read are single-cycle registered operations.

Optional Feature:
PERF_CNT_THRESH_EN
- Defined: adds these ports:
  - thr_wr in 1
  - thr_sel in SEL_W
  - thr_val in CNT_W
  - thr_hit out NUM_CH
- Per-channel threshold registers reset to all-ones; thr_wr loads thr_val into the threshold selected by thr_sel.
- thr_hit[i] is sticky. It sets on the cycle after the live counter first becomes >= its threshold, and clears on clr or rst.
- A threshold write and a crossing in the same cycle compare against the old threshold.
- Undefined: none of these ports or registers exist; all other behaviour is identical.

Decomposition:
- Shared package perf_pkg holds:
  - default constants PERF_NUM_CH, PERF_CNT_W, PERF_INC_W
  - channel index localparams, mapping hit=0, miss=1, evict=2, dirty_evict=3, pred_hit=4, pred_miss=5, stale=6
  - a function computing the saturating/wrapping sum
- One sub-module, perf_counter_cell, instantiated NUM_CH times via generate. Each cell owns its live counter, shadow, ovf bit and optional threshold.
- The top handles the read mux, snap_done and ovf_any.

Test Plan:
1. Basic count and read: reset; drive ch0 with inc=1 for 10 cycles and ch3 with inc=5 for 4 cycles. Read live ch0 and ch3 -> 10 and 20, each with rd_valid one cycle after rd_req.
2. Wrap vs saturate: CNT_W=8, cfg_sat=0, preload ch1 to 254, inc=3 -> 1 with ovf[1]=1, and ovf_any=1 one cycle later. Same test with cfg_sat=1 -> 255 and ovf[1]=1.
3. Enable mask: ch_en[2]=0 while inc=7 for 5 cycles -> ch2 stays 0. Re-enable for 1 cycle -> 7.
4. Snapshot plus clear: ch0=42; assert snap and clr together with inc=1. Expect shadow ch0=42, live ch0=0 next cycle, and snap_done pulses once.
5. Simultaneous read and update: ch4=9 with inc=2 on the same edge as rd_req for ch4 -> rd_data=9, live becomes 11. Out-of-range rd_sel=7 with NUM_CH=6 -> rd_data=0, rd_valid=1.
6. Reset mid-operation: rst during back-to-back reads with snap pending -> rd_valid=0, snap_done=0, and all counters and ovf=0 the next cycle.
